// File: rtl/sar_search_4bit_pkg.sv
// Shared definitions for the successive-approximation search controller:
// default word width and the controller state encoding.
package sar_search_4bit_pkg;

    localparam int SAR_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/sar_search_4bit.sv
// Successive-approximation search controller. Drives trial words onto the B
// side of an external combinational comparator and walks the bits MSB-first
// using the lt/eq/gt flags until the unknown A is recovered. Exits early on
// equality and aborts with err when the flags are not one-hot or cannot
// belong to a static A.
//
// Handshake: start is sampled only in IDLE. busy is high exactly while in
// SEARCH. done is a single-cycle pulse (never together with busy) that marks
// result/err valid. result/err hold until the next accepted start.
module sar_search_4bit
    import sar_search_4bit_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic [1:0]       state_dbg
);

    localparam int                IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0]  IDX_TOP = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE = IDX_W'(1);
    localparam logic [WIDTH-1:0]  ONE     = WIDTH'(1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   trial_q, trial_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   adjusted;
    logic               flags_ok;

    // Next-state and datapath: start a search, refine one bit per compare, finish.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        trial_d  = trial_q;
        result_d = result_q;
        err_d    = err_q;
        adjusted = trial_q;
        flags_ok = $onehot({cmp_lt, cmp_eq, cmp_gt});

        case (state_q)
            IDLE: begin
                if (start) begin
                    trial_d  = ONE << IDX_TOP;
                    idx_d    = IDX_TOP;
                    result_d = '0;
                    err_d    = 1'b0;
                    state_d  = SEARCH;
                end
            end

            SEARCH: begin
                // A below the trial means the bit under test must be cleared.
                if (cmp_lt) begin
                    adjusted[idx_q] = 1'b0;
                end

                if (!flags_ok) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = DONE;
                end else if (cmp_eq) begin
                    result_d = trial_q;
                    state_d  = DONE;
                end else if (idx_q != '0) begin
                    trial_d = adjusted | (ONE << (idx_q - IDX_ONE));
                    idx_d   = idx_q - IDX_ONE;
                end else if (cmp_lt) begin
                    result_d = adjusted;
                    state_d  = DONE;
                end else begin
                    // gt on the last bit means A moved during the search.
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = DONE;
                end
            end

            DONE: begin
                trial_d = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= IDX_TOP;
            trial_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign trial     = trial_q;
    assign busy      = (state_q == SEARCH);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sar_search_4bit.sv
// Bench for sar_search_4bit: a behavioural comparator closes the loop around
// the controller, with optional flag faults; expected outcomes are queued at
// start and popped at the done pulse.
module tb_sar_search_4bit;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic         cmp_lt, cmp_eq, cmp_gt;
    logic [W-1:0] trial;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         err;
    logic [1:0]   state_dbg;

    logic [W-1:0] a_val;
    logic [W-1:0] a_eff;
    int           fault_mode;
    int           cmp_cycle;

    int n_checks;
    int n_fail;

    logic [W-1:0] exp_q[$];
    logic         exp_err_q[$];
    int           exp_lat_q[$];
    logic [W-1:0] trace[1:16];

    sar_search_4bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cmp_lt    (cmp_lt),
        .cmp_eq    (cmp_eq),
        .cmp_gt    (cmp_gt),
        .trial     (trial),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural unsigned comparator with fault injection.
    // fault_mode 1: flags 000 in compare cycle 2. fault_mode 2: A becomes 15 from cycle 4.
    always_comb begin
        a_eff = a_val;
        if (fault_mode == 2 && cmp_cycle >= 4) a_eff = 4'd15;
        cmp_lt = (a_eff < trial);
        cmp_eq = (a_eff == trial);
        cmp_gt = (a_eff > trial);
        if (fault_mode == 1 && cmp_cycle == 2) begin
            cmp_lt = 1'b0;
            cmp_eq = 1'b0;
            cmp_gt = 1'b0;
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_search(input logic [W-1:0] a, input logic [W-1:0] exp_res,
                              input logic exp_err, input int exp_k,
                              input int pulse_c, input logic hold, input int fmode);
        int c;
        logic got;
        logic [W-1:0] r_exp;
        logic e_exp;
        int l_exp;
        @(negedge clk);
        a_val = a;
        fault_mode = fmode;
        cmp_cycle = 0;
        start = 1'b1;
        exp_q.push_back(exp_res);
        exp_err_q.push_back(exp_err);
        exp_lat_q.push_back(exp_k + 1);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        c = 0;
        got = 1'b0;
        while (!got && c < 3 * W) begin
            @(negedge clk);
            c++;
            cmp_cycle = c;
            if (pulse_c > 0) start = (c == pulse_c) ? 1'b1 : hold;
            if (done) begin
                got = 1'b1;
                r_exp = exp_q.pop_front();
                e_exp = exp_err_q.pop_front();
                l_exp = exp_lat_q.pop_front();
                n_checks++;
                if (c !== l_exp) begin
                    n_fail++;
                    $display("FAIL latency a=%0d: done in cycle %0d, required %0d", a, c, l_exp);
                end
                n_checks++;
                if (result !== r_exp) begin
                    n_fail++;
                    $display("FAIL result a=%0d: got %0d, required %0d", a, result, r_exp);
                end
                n_checks++;
                if (err !== e_exp) begin
                    n_fail++;
                    $display("FAIL err a=%0d: got %b, required %b", a, err, e_exp);
                end
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_with_done a=%0d: busy=%b, required 0", a, busy);
                end
            end else begin
                trace[c] = trial;
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy a=%0d cycle %0d: got %b, required 1", a, c, busy);
                end
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout a=%0d: no done within %0d cycles", a, 3 * W);
            void'(exp_q.pop_front());
            void'(exp_err_q.pop_front());
            void'(exp_lat_q.pop_front());
        end
        cmp_cycle = 0;
        fault_mode = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (trial !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || result !== 4'd0 ||
            err !== 1'b0 || state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL reset: trial=%0d busy=%b done=%b result=%0d err=%b state=%0d, required all 0",
                     trial, busy, done, result, err, state_dbg);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [W-1:0] exp_tr[4];
        exp_tr = '{4'd8, 4'd4, 4'd6, 4'd5};
        run_search(4'd0, 4'd0, 1'b0, 4, 0, 1'b0, 0);
        run_search(4'd15, 4'd15, 1'b0, 4, 0, 1'b0, 0);
        run_search(4'd8, 4'd8, 1'b0, 1, 0, 1'b0, 0);
        run_search(4'd5, 4'd5, 1'b0, 4, 0, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (trace[i+1] !== exp_tr[i]) begin
                n_fail++;
                $display("FAIL trace a=5 step %0d: trial=%0d, required %0d", i + 1, trace[i+1], exp_tr[i]);
            end
        end
    endtask

    task automatic test_flag_faults();
        run_search(4'd5, 4'd0, 1'b1, 2, 0, 1'b0, 1);
        run_search(4'd0, 4'd0, 1'b1, 4, 0, 1'b0, 2);
        run_search(4'd9, 4'd9, 1'b0, 4, 0, 1'b0, 0);
    endtask

    task automatic test_start_ignored();
        logic extra;
        run_search(4'd6, 4'd6, 1'b0, 3, 2, 1'b0, 0);
        start = 1'b0;
        extra = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) extra = 1'b1;
        end
        n_checks++;
        if (extra !== 1'b0) begin
            n_fail++;
            $display("FAIL start_ignored: activity after done=%b, required 0", extra);
        end
    endtask

    task automatic test_reset_mid_search();
        logic saw_done;
        @(negedge clk);
        a_val = 4'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (trial !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || result !== 4'd0 ||
            err !== 1'b0 || state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_mid: trial=%0d busy=%b done=%b result=%0d err=%b state=%0d, required all 0",
                     trial, busy, done, result, err, state_dbg);
        end
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: done/busy seen=%b, required 0", saw_done);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        logic got;
        logic [W-1:0] r_exp;
        logic e_exp;
        int l_exp;
        run_search(4'd3, 4'd3, 1'b0, 4, 0, 1'b1, 0);
        a_val = 4'd10;
        exp_q.push_back(4'd10);
        exp_err_q.push_back(1'b0);
        exp_lat_q.push_back(4);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL b2b_idle: busy=%b done=%b state=%0d, required 0 0 0", busy, done, state_dbg);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || trial !== 4'd8) begin
            n_fail++;
            $display("FAIL b2b_restart: busy=%b trial=%0d, required 1 8", busy, trial);
        end
        start = 1'b0;
        c = 1;
        got = 1'b0;
        while (!got && c < 3 * W) begin
            @(negedge clk);
            c++;
            if (done) begin
                got = 1'b1;
                r_exp = exp_q.pop_front();
                e_exp = exp_err_q.pop_front();
                l_exp = exp_lat_q.pop_front();
                n_checks++;
                if (c !== l_exp || result !== r_exp || err !== e_exp) begin
                    n_fail++;
                    $display("FAIL b2b_second: cycle=%0d result=%0d err=%b, required %0d %0d %b",
                             c, result, err, l_exp, r_exp, e_exp);
                end
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL b2b_timeout: no done for second search");
            void'(exp_q.pop_front());
            void'(exp_err_q.pop_front());
            void'(exp_lat_q.pop_front());
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        start = 1'b0;
        a_val = '0;
        fault_mode = 0;
        cmp_cycle = 0;
        test_reset();
        test_basic();
        test_flag_faults();
        test_start_ignored();
        test_reset_mid_search();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
